// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM.
// Holds the state enum, opcode and ALU-op encodings, and the control bundle type.
package ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned SEL_W   = 2;

   localparam logic [OP_W-1:0] OP_R    = 6'h00;
   localparam logic [OP_W-1:0] OP_LW   = 6'h23;
   localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
   localparam logic [OP_W-1:0] OP_J    = 6'h02;

   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } ctrl_state_t;

   typedef struct packed {
      logic               iord;
      logic               memread;
      logic               memwrite;
      logic               irwrite;
      logic               regwrite;
      logic               regdst;
      logic               memtoreg;
      logic               alusrca;
      logic [SEL_W-1:0]   alusrcb;
      logic [ALUOP_W-1:0] aluop;
      logic [SEL_W-1:0]   pcsrc;
      logic               pcwrite;
      logic               pcwritecond;
   } ctrl_sig_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational decode of FSM state (and memory ready) into datapath controls.
module ctrl_outdec
   import ctrl_pkg::*;
(
   input  ctrl_state_t state,
   input  logic        mem_ready,
   output ctrl_sig_t   sig
);

   always_comb begin
      sig = '0;
      case (state)
         S_FETCH: begin
            sig.memread = 1'b1;
            sig.alusrcb = SRCB_FOUR;
            sig.aluop   = ALUOP_ADD;
            sig.irwrite = mem_ready;
            sig.pcwrite = mem_ready;
         end
         // Branch target is precomputed while the opcode is being decoded.
         S_DECODE: begin
            sig.alusrcb = SRCB_IMMSH;
            sig.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            sig.alusrca = 1'b1;
            sig.alusrcb = SRCB_IMM;
            sig.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            sig.iord    = 1'b1;
            sig.memread = 1'b1;
         end
         S_MEMWR: begin
            sig.iord     = 1'b1;
            sig.memwrite = mem_ready;
         end
         S_MEMWB: begin
            sig.regwrite = 1'b1;
            sig.memtoreg = 1'b1;
         end
         S_EXEC: begin
            sig.alusrca = 1'b1;
            sig.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            sig.regwrite = 1'b1;
            sig.regdst   = 1'b1;
         end
         S_ADDIWB: sig.regwrite = 1'b1;
         S_BRANCH: begin
            sig.alusrca     = 1'b1;
            sig.aluop       = ALUOP_SUB;
            sig.pcsrc       = PCSRC_ALUOUT;
            sig.pcwritecond = 1'b1;
         end
         S_JUMP: begin
            sig.pcwrite = 1'b1;
            sig.pcsrc   = PCSRC_JUMP;
         end
         default: sig = '0;
      endcase
   end

endmodule

// File: rtl/mcctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and counts retired instructions.
module mcctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned n = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               iord,
   output logic               memread,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               alusrca,
   output logic [SEL_W-1:0]   alusrcb,
   output logic [ALUOP_W-1:0] aluop,
   output logic [SEL_W-1:0]   pcsrc,
   output logic               pcwrite,
   output logic               pcwritecond,
   output logic               illegal,
   output logic [n-1:0]       instret
);

   ctrl_state_t state_q, state_d;
   logic        lw_q;
   logic        retire;
   ctrl_sig_t   sig;

   // zero qualifies pcwritecond inside the datapath, so the FSM ignores it.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         lw_q    <= 1'b0;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) lw_q <= (opcode == OP_LW);
         if (retire) instret <= instret + n'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      illegal = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = lw_q ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .sig       (sig)
   );

   assign iord        = sig.iord;
   assign memread     = sig.memread;
   assign memwrite    = sig.memwrite;
   assign irwrite     = sig.irwrite;
   assign regwrite    = sig.regwrite;
   assign regdst      = sig.regdst;
   assign memtoreg    = sig.memtoreg;
   assign alusrca     = sig.alusrca;
   assign alusrcb     = sig.alusrcb;
   assign aluop       = sig.aluop;
   assign pcsrc       = sig.pcsrc;
   assign pcwrite     = sig.pcwrite;
   assign pcwritecond = sig.pcwritecond;

endmodule

// File: tb/tb_mcctrl.sv
// Self-checking bench for mcctrl: instruction-level step model plus directed
// literal checks, then randomized opcodes, wait states and resets.
`timescale 1ns/1ps
module tb_mcctrl;

   typedef struct packed {
      logic       iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, aluop, pcsrc;
      logic       pcwrite, pcwritecond, illegal;
   } ov_t;

   typedef enum {T_F, T_D, T_MA, T_MR, T_MWB, T_MWR, T_EX, T_AWB, T_IEX, T_IWB, T_BR, T_JMP} step_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic pcwrite, pcwritecond, illegal;
   logic [31:0] instret;

   logic iord_s, memread_s, memwrite_s, irwrite_s, regwrite_s, regdst_s, memtoreg_s, alusrca_s;
   logic [1:0] alusrcb_s, aluop_s, pcsrc_s;
   logic pcwrite_s, pcwritecond_s, illegal_s;
   logic [2:0] instret_s;

   ov_t dut_o, dut_s;
   assign dut_o = {iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                   alusrcb, aluop, pcsrc, pcwrite, pcwritecond, illegal};
   assign dut_s = {iord_s, memread_s, memwrite_s, irwrite_s, regwrite_s, regdst_s, memtoreg_s,
                   alusrca_s, alusrcb_s, aluop_s, pcsrc_s, pcwrite_s, pcwritecond_s, illegal_s};

   mcctrl #(.n(32)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcwrite(pcwrite),
      .pcwritecond(pcwritecond), .illegal(illegal), .instret(instret)
   );

   // Narrow counter instance exercises wrap-around in a short run.
   mcctrl #(.n(3)) dut_small (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord_s), .memread(memread_s), .memwrite(memwrite_s), .irwrite(irwrite_s),
      .regwrite(regwrite_s), .regdst(regdst_s), .memtoreg(memtoreg_s), .alusrca(alusrca_s),
      .alusrcb(alusrcb_s), .aluop(aluop_s), .pcsrc(pcsrc_s), .pcwrite(pcwrite_s),
      .pcwritecond(pcwritecond_s), .illegal(illegal_s), .instret(instret_s)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   step_t       route[$];
   int          pos;
   logic [5:0]  cur_op;
   bit          rand_ops = 1'b0;
   longint      retired;
   int          mw_count;
   int          rw_seen;

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
   endfunction

   function automatic logic [5:0] pick_op();
      logic [5:0] tbl [6];
      tbl = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
      if ($urandom_range(0, 6) == 0) return 6'($urandom);
      return tbl[$urandom_range(0, 5)];
   endfunction

   // Step list an instruction walks through, straight from the state flow.
   task automatic build_route(input logic [5:0] op);
      route.delete();
      route.push_back(T_F);
      route.push_back(T_D);
      case (op)
         6'h23: begin route.push_back(T_MA); route.push_back(T_MR); route.push_back(T_MWB); end
         6'h2B: begin route.push_back(T_MA); route.push_back(T_MWR); end
         6'h00: begin route.push_back(T_EX); route.push_back(T_AWB); end
         6'h08: begin route.push_back(T_IEX); route.push_back(T_IWB); end
         6'h04: route.push_back(T_BR);
         6'h02: route.push_back(T_JMP);
         default: ;
      endcase
   endtask

   function automatic ov_t expect_out(input step_t s, input logic mr, input logic [5:0] op);
      ov_t e;
      e = '0;
      case (s)
         T_F:   begin e.memread = 1; e.alusrcb = 2'b01; e.aluop = 2'b10; e.irwrite = mr; e.pcwrite = mr; end
         T_D:   begin e.alusrcb = 2'b11; e.aluop = 2'b10; e.illegal = !is_legal(op); end
         T_MA, T_IEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b10; end
         T_MR:  begin e.iord = 1; e.memread = 1; end
         T_MWR: begin e.iord = 1; e.memwrite = mr; end
         T_MWB: begin e.regwrite = 1; e.memtoreg = 1; end
         T_EX:  begin e.alusrca = 1; e.aluop = 2'b00; end
         T_AWB: begin e.regwrite = 1; e.regdst = 1; end
         T_IWB: e.regwrite = 1;
         T_BR:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcwritecond = 1; end
         T_JMP: begin e.pcwrite = 1; e.pcsrc = 2'b10; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic model_reset();
      pos = 0;
      retired = 0;
      build_route(cur_op);
   endtask

   task automatic set_op(input logic [5:0] op);
      cur_op = op;
      build_route(op);
   endtask

   task automatic advance(input logic mr);
      step_t s;
      s = route[pos];
      if ((s == T_F || s == T_MR || s == T_MWR) && !mr) return;
      pos++;
      if (pos == route.size()) begin
         if (is_legal(cur_op)) retired++;
         pos = 0;
         if (rand_ops) cur_op = pick_op();
         build_route(cur_op);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      ov_t e;
      e = expect_out(route[pos], mem_ready, cur_op);
      chk("outputs", 32'(dut_o), 32'(e));
      chk("outputs_n3", 32'(dut_s), 32'(e));
      chk("instret", instret, 32'(retired));
      chk("instret_n3", 32'(instret_s), 32'(retired % 8));
   endtask

   // One clock: drive at the falling edge, check 1ns later, step model on the rising edge.
   task automatic cycle(input logic mr, input logic z, input logic rn);
      reset_n   = rn;
      if (!rn) model_reset();
      mem_ready = mr;
      zero      = z;
      opcode    = cur_op;
      #1;
      compare();
      if (memwrite === 1'b1) mw_count++;
      if (regwrite === 1'b1) rw_seen++;
      @(posedge clk);
      if (!reset_n) model_reset(); else advance(mr);
      @(negedge clk);
   endtask

   initial begin
      logic sw_pat [9];
      sw_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      cur_op = 6'h23;
      model_reset();
      @(negedge clk);
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      #1;
      chk("rst_fetch_outputs", 32'(dut_o), 32'(17'b01010000_01_10_00_100));
      chk("rst_instret", instret, 32'd0);

      // LW, no waits: 5 cycles
      set_op(6'h23);
      for (int i = 0; i < 4; i++) cycle(1, 0, 1);
      #1;
      chk("lw_c5_wb", 32'({regwrite, memtoreg}), 32'd3);
      cycle(1, 0, 1);
      #1;
      chk("lw_retired", instret, 32'd1);
      chk("lw_back_fetch", 32'({memread, iord}), 32'd2);

      // SW with 3 fetch waits and 2 write waits: 9 cycles, single memwrite
      set_op(6'h2B);
      mw_count = 0;
      for (int i = 0; i < 8; i++) cycle(sw_pat[i], 0, 1);
      #1;
      chk("sw_c9_iord", 32'(iord), 32'd1);
      cycle(sw_pat[8], 0, 1);
      #1;
      chk("sw_memwrite_count", 32'(mw_count), 32'd1);
      chk("sw_retired", instret, 32'd2);

      // BEQ with zero low then high: both retire
      set_op(6'h04);
      for (int i = 0; i < 2; i++) cycle(1, 0, 1);
      #1;
      chk("beq_branch_ctl", 32'({aluop, pcwritecond}), 32'b011);
      cycle(1, 0, 1);
      for (int i = 0; i < 3; i++) cycle(1, 1, 1);
      #1;
      chk("beq_retired", instret, 32'd4);

      // Illegal opcode: one-cycle pulse, back to FETCH, no retire
      set_op(6'h3F);
      cycle(1, 0, 1);
      #1;
      chk("illegal_pulse", 32'(illegal), 32'd1);
      cycle(1, 0, 1);
      #1;
      chk("illegal_then_fetch", 32'({illegal, memread}), 32'b01);
      chk("illegal_no_retire", instret, 32'd4);

      // R-type
      set_op(6'h00);
      for (int i = 0; i < 2; i++) cycle(1, 0, 1);
      #1;
      chk("r_exec_ctl", 32'({alusrca, aluop}), 32'b100);
      cycle(1, 0, 1);
      #1;
      chk("r_aluwb_ctl", 32'({regwrite, regdst}), 32'b11);
      cycle(1, 0, 1);

      // Jumps: counter reaches 8, narrow copy wraps to 0
      set_op(6'h02);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1);
      #1;
      chk("j_retired", instret, 32'd6);
      chk("j_retired_n3", 32'(instret_s), 32'd6);
      for (int i = 0; i < 6; i++) cycle(1, 0, 1);
      #1;
      chk("wrap_n3", 32'(instret_s), 32'd0);
      chk("nowrap_n32", instret, 32'd8);

      // Reset during MEMRD aborts the load without writeback
      set_op(6'h23);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1);
      rw_seen = 0;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_abort_fetch", 32'({iord, memread, regwrite}), 32'b010);
      chk("rst_abort_instret", instret, 32'd0);
      cycle(1, 0, 0);
      cycle(1, 0, 1);
      cycle(1, 0, 1);
      chk("rst_abort_no_regwrite", 32'(rw_seen), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1);

      // Randomized opcodes, wait states, zero flag and occasional resets
      rand_ops = 1'b1;
      cur_op = pick_op();
      reset_n = 1'b0;
      cycle(1, 0, 0);
      for (int i = 0; i < 5000; i++) begin
         cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 399) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
